// File: rtl/riscv_defines.sv
`timescale 1ns/1ps
// Shared core definitions: ALU operator encodings and vector modes.
package riscv_defines;

    localparam int unsigned ALU_OP_WIDTH = 7;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 7'b0011001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 7'b0101111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 7'b0101110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 7'b0010101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 7'b0000010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 7'b0000011;

    localparam logic [1:0] VEC_MODE32 = 2'b00;
    localparam logic [1:0] VEC_MODE16 = 2'b10;
    localparam logic [1:0] VEC_MODE8  = 2'b11;

endpackage

// File: rtl/riscv_shared_alu_client_pkg.sv
`timescale 1ns/1ps
// Local types for the shared-ALU client: FSM states and request payload.
package riscv_shared_alu_client_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned TAG_W_DEF   = 2;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } state_t;

    // Operand bundle as it appears on the bus: {c, b, a}
    typedef struct packed {
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } operands_t;

endpackage

// File: rtl/riscv_shared_alu_client_if.sv
`timescale 1ns/1ps
// Tagged req/gnt + rvalid link between a core-side client and the shared ALU cluster.
interface riscv_shared_alu_client_if #(
    parameter int unsigned TAG_W = riscv_shared_alu_client_pkg::TAG_W_DEF
) ();

    logic                                       req;
    logic                                       gnt;
    logic [riscv_defines::ALU_OP_WIDTH-1:0]     op;
    riscv_shared_alu_client_pkg::operands_t     operands;
    logic [1:0]                                 flags;
    logic [TAG_W-1:0]                           tag;
    logic                                       rvalid;
    logic [TAG_W-1:0]                           rtag;
    logic [riscv_shared_alu_client_pkg::DATA_W-1:0] result;
    logic                                       cmp;

    modport master (
        output req, op, operands, flags, tag,
        input  gnt, rvalid, rtag, result, cmp
    );

    modport slave (
        input  req, op, operands, flags, tag,
        output gnt, rvalid, rtag, result, cmp
    );

endinterface

// File: rtl/riscv_shared_alu_client.sv
`timescale 1ns/1ps
// EX-stage front end that offloads one ALU op to the shared cluster and
// buffers the tagged response until the pipeline takes it.
module riscv_shared_alu_client
    import riscv_defines::*;
    import riscv_shared_alu_client_pkg::*;
#(
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [ALU_OP_WIDTH-1:0] operator_i,
    input  logic [DATA_W-1:0]       operand_a_i,
    input  logic [DATA_W-1:0]       operand_b_i,
    input  logic [DATA_W-1:0]       operand_c_i,
    input  logic [1:0]              vector_mode_i,
    input  logic                    flush_i,
    input  logic                    ex_ready_i,
    output logic                    ready_o,
    output logic [DATA_W-1:0]       result_o,
    output logic                    comparison_result_o,
    output logic                    error_o,
    riscv_shared_alu_client_if.master apu
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                  state, next_state;
    logic [TAG_W-1:0]        tag_q, pend_tag_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    req_q;
    logic [ALU_OP_WIDTH-1:0] op_q;
    operands_t               operands_q;
    logic [1:0]              flags_q;
    logic [DATA_W-1:0]       result_q;
    logic                    cmp_q;
    logic                    error_q;

    logic grant_c, hit_req_c, hit_wait_c, expired_c;
    logic capture_op_c, capture_rsp_c, capture_err_c;

    // In REQ the live tag is the request's; after the grant it has advanced, so match the saved copy
    assign grant_c    = (state == REQ) && apu.gnt;
    assign hit_req_c  = apu.gnt && apu.rvalid && (apu.rtag == tag_q);
    assign hit_wait_c = apu.rvalid && (apu.rtag == pend_tag_q);
    assign expired_c  = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state    = state;
        ready_o       = 1'b0;
        capture_op_c  = 1'b0;
        capture_rsp_c = 1'b0;
        capture_err_c = 1'b0;
        unique case (state)
            IDLE: begin
                ready_o = !enable_i;
                if (enable_i && !flush_i) begin
                    next_state   = REQ;
                    capture_op_c = 1'b1;
                end
            end
            REQ: begin
                // A flushed op whose response already came back with the grant has nothing left to drain
                if (flush_i) begin
                    if (!apu.gnt || hit_req_c) next_state = IDLE;
                    else                       next_state = DRAIN;
                end else if (apu.gnt) begin
                    if (hit_req_c) begin
                        next_state    = DONE;
                        capture_rsp_c = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush_i) begin
                    next_state = DRAIN;
                end else if (hit_wait_c) begin
                    next_state    = DONE;
                    capture_rsp_c = 1'b1;
                end else if (expired_c) begin
                    next_state    = DONE;
                    capture_err_c = 1'b1;
                end
            end
            DONE: begin
                ready_o = 1'b1;
                if (flush_i || ex_ready_i) next_state = IDLE;
            end
            DRAIN: begin
                if (hit_wait_c || expired_c) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request strobe, tag and timeout bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            tag_q      <= '0;
            pend_tag_q <= '0;
            cnt_q      <= '0;
        end else begin
            req_q <= (next_state == REQ);
            if (grant_c) begin
                tag_q      <= tag_q + TAG_W'(1);
                pend_tag_q <= tag_q;
                cnt_q      <= '0;
            end else if (state == WAIT || state == DRAIN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Request payload and buffered completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            operands_q <= '0;
            flags_q    <= '0;
            result_q   <= '0;
            cmp_q      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            if (capture_op_c) begin
                op_q       <= operator_i;
                operands_q <= '{c: operand_c_i, b: operand_b_i, a: operand_a_i};
                flags_q    <= vector_mode_i;
            end
            if (capture_rsp_c) begin
                result_q <= apu.result;
                cmp_q    <= apu.cmp;
                error_q  <= 1'b0;
            end else if (capture_err_c) begin
                result_q <= '0;
                cmp_q    <= 1'b0;
                error_q  <= 1'b1;
            end
        end
    end

    assign apu.req             = req_q;
    assign apu.op              = op_q;
    assign apu.operands        = operands_q;
    assign apu.flags           = flags_q;
    assign apu.tag             = tag_q;
    assign result_o            = result_q;
    assign comparison_result_o = cmp_q;
    assign error_o             = error_q;

endmodule

// File: tb/tb_riscv_shared_alu_client.sv
`timescale 1ns/1ps
// Directed bench for riscv_shared_alu_client; the bench plays the shared ALU cluster.
module tb_riscv_shared_alu_client;
    import riscv_defines::*;
    import riscv_shared_alu_client_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    enable;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [31:0]             opa, opb, opc;
    logic [1:0]              vmode;
    logic                    flush;
    logic                    ex_ready;
    logic                    ready;
    logic [31:0]             result;
    logic                    cmp;
    logic                    err;

    int n_cmp;
    int n_err;
    int req_cycles;

    riscv_shared_alu_client_if #(.TAG_W(2)) apu ();

    riscv_shared_alu_client #(.TAG_W(2), .TIMEOUT(64)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable_i            (enable),
        .operator_i          (op),
        .operand_a_i         (opa),
        .operand_b_i         (opb),
        .operand_c_i         (opc),
        .vector_mode_i       (vmode),
        .flush_i             (flush),
        .ex_ready_i          (ex_ready),
        .ready_o             (ready),
        .result_o            (result),
        .comparison_result_o (cmp),
        .error_o             (err),
        .apu                 (apu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic count_req();
        if (apu.req === 1'b1) req_cycles++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; req_cycles = 0;
        rst_n = 1'b0; enable = 1'b0; op = '0; opa = '0; opb = '0; opc = '0;
        vmode = VEC_MODE32; flush = 1'b0; ex_ready = 1'b0;
        apu.gnt = 1'b0; apu.rvalid = 1'b0; apu.rtag = '0; apu.result = '0; apu.cmp = 1'b0;

        // Reset values
        cyc(); cyc();
        chk("rst_ready",  32'(ready),   32'd1);
        chk("rst_req",    32'(apu.req), 32'd0);
        chk("rst_tag",    32'(apu.tag), 32'd0);
        chk("rst_result", result,       32'd0);
        chk("rst_cmp",    32'(cmp),     32'd0);
        chk("rst_err",    32'(err),     32'd0);
        rst_n = 1'b1;
        cyc();

        // ADD 5+7: gnt in 3rd req cycle, response 3 cycles later
        enable = 1'b1; op = ALU_ADD; opa = 32'd5; opb = 32'd7; opc = 32'd0;
        #1 chk("idle_busy_ready", 32'(ready), 32'd0);
        cyc(); count_req();
        chk("add_req",   32'(apu.req),        32'd1);
        chk("add_op",    32'(apu.op),         32'(ALU_ADD));
        chk("add_a",     apu.operands.a,      32'd5);
        chk("add_b",     apu.operands.b,      32'd7);
        chk("add_tag",   32'(apu.tag),        32'd0);
        chk("req_ready", 32'(ready),          32'd0);
        cyc(); count_req();
        cyc(); count_req(); apu.gnt = 1'b1;
        cyc(); count_req(); apu.gnt = 1'b0;
        chk("add_req_cycles", 32'(req_cycles), 32'd3);
        chk("add_tag_inc",    32'(apu.tag),    32'd1);
        cyc(); cyc();
        chk("wait_ready", 32'(ready), 32'd0);
        apu.rvalid = 1'b1; apu.rtag = 2'd0; apu.result = 32'd12; apu.cmp = 1'b0;
        cyc(); apu.rvalid = 1'b0;
        chk("add_done_ready", 32'(ready), 32'd1);
        chk("add_result",     result,     32'd12);
        chk("add_err",        32'(err),   32'd0);
        ex_ready = 1'b1;
        cyc();
        ex_ready = 1'b0; enable = 1'b0;
        #1 chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_req", 32'(apu.req), 32'd0);

        // SLTS with gnt and response in the first req cycle
        enable = 1'b1; op = ALU_SLTS; opa = 32'hFFFF_FFFF; opb = 32'd3;
        cyc();
        chk("slts_req", 32'(apu.req), 32'd1);
        chk("slts_tag", 32'(apu.tag), 32'd1);
        apu.gnt = 1'b1; apu.rvalid = 1'b1; apu.rtag = 2'd1; apu.result = 32'd1; apu.cmp = 1'b1;
        cyc(); apu.gnt = 1'b0; apu.rvalid = 1'b0;
        chk("slts_ready",  32'(ready),   32'd1);
        chk("slts_cmp",    32'(cmp),     32'd1);
        chk("slts_result", result,       32'd1);
        chk("slts_req_lo", 32'(apu.req), 32'd0);
        chk("slts_tag2",   32'(apu.tag), 32'd2);

        // Back-pressure in DONE, then a fresh op without duplicate issue
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("hold_ready",  32'(ready), 32'd1);
            chk("hold_result", result,     32'd1);
        end
        ex_ready = 1'b1;
        cyc();
        ex_ready = 1'b0; op = ALU_SUB; opa = 32'd10; opb = 32'd3;
        #1 chk("no_dup_req", 32'(apu.req), 32'd0);
        cyc();
        chk("sub_req", 32'(apu.req),   32'd1);
        chk("sub_tag", 32'(apu.tag),   32'd2);
        chk("sub_a",   apu.operands.a, 32'd10);
        apu.gnt = 1'b1;
        cyc(); apu.gnt = 1'b0;
        chk("sub_wait_req", 32'(apu.req), 32'd0);
        chk("sub_tag_inc",  32'(apu.tag), 32'd3);

        // Flush in WAIT, stale response, then the matching one
        flush = 1'b1; enable = 1'b0;
        cyc(); flush = 1'b0;
        #1 chk("drain_ready", 32'(ready), 32'd0);
        apu.rvalid = 1'b1; apu.rtag = 2'd1; apu.result = 32'd99; apu.cmp = 1'b0;
        cyc();
        chk("stale_ready", 32'(ready), 32'd0);
        apu.rtag = 2'd2; apu.result = 32'd55;
        #1 chk("match_cycle_ready", 32'(ready), 32'd0);
        cyc(); apu.rvalid = 1'b0;
        #1 chk("drain_idle_ready", 32'(ready), 32'd1);
        chk("drain_result", result,   32'd1);
        chk("drain_cmp",    32'(cmp), 32'd1);
        chk("drain_err",    32'(err), 32'd0);

        // Timeout: no response for 64 WAIT cycles
        enable = 1'b1; op = ALU_XOR; opa = 32'd1; opb = 32'd2;
        cyc();
        chk("xor_tag", 32'(apu.tag), 32'd3);
        apu.gnt = 1'b1;
        cyc(); apu.gnt = 1'b0;
        chk("tag_wrap", 32'(apu.tag), 32'd0);
        repeat (63) cyc();
        chk("pre_timeout_ready", 32'(ready), 32'd0);
        cyc();
        chk("timeout_ready",  32'(ready), 32'd1);
        chk("timeout_err",    32'(err),   32'd1);
        chk("timeout_result", result,     32'd0);
        chk("timeout_cmp",    32'(cmp),   32'd0);
        ex_ready = 1'b1; enable = 1'b0;
        cyc(); ex_ready = 1'b0;

        // Next op ignores the late response of the timed-out one
        enable = 1'b1; op = ALU_AND; opa = 32'hF0; opb = 32'h3C;
        cyc();
        chk("and_tag", 32'(apu.tag), 32'd0);
        apu.gnt = 1'b1;
        cyc(); apu.gnt = 1'b0;
        apu.rvalid = 1'b1; apu.rtag = 2'd3; apu.result = 32'd77; apu.cmp = 1'b1;
        cyc();
        chk("late_ignored_ready", 32'(ready), 32'd0);
        apu.rtag = 2'd0; apu.result = 32'hABCD; apu.cmp = 1'b0;
        cyc(); apu.rvalid = 1'b0;
        chk("and_ready",  32'(ready), 32'd1);
        chk("and_result", result,     32'hABCD);
        chk("and_err",    32'(err),   32'd0);
        chk("and_cmp",    32'(cmp),   32'd0);

        // Reset while in REQ
        ex_ready = 1'b1; op = ALU_ADD; opa = 32'd1; opb = 32'd1;
        cyc(); ex_ready = 1'b0;
        cyc();
        chk("pre_rst_req", 32'(apu.req), 32'd1);
        chk("pre_rst_tag", 32'(apu.tag), 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_mid_req", 32'(apu.req), 32'd0);
        chk("rst_mid_tag",    32'(apu.tag), 32'd0);
        chk("rst_mid_result", result,       32'd0);
        enable = 1'b0;
        #1 chk("rst_mid_ready", 32'(ready), 32'd1);
        cyc(); rst_n = 1'b1;
        cyc();
        chk("post_rst_ready", 32'(ready),   32'd1);
        chk("post_rst_req",   32'(apu.req), 32'd0);
        chk("post_rst_tag",   32'(apu.tag), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_shared_alu_client.md
Name: riscv_shared_alu_client

Overview:
- Core-side initiator for an ALU operation offloaded to a shared DSP/ALU cluster, where the cluster is the responder.
- Sits in the EX stage and presents the same pipeline contract as a local ALU: operator, operands and vector mode in; result, comparison flag and ready_o out; ex_ready_i back-pressure.
- Converts each EX operation into one tagged req/gnt request plus an rvalid response.
- Buffers the result until the pipeline consumes it, and handles flush and timeout.

Parameters:
- ALU_OP_WIDTH, 7: operator field width (shared package constant).
- TAG_W, 2: request tag width.
- TIMEOUT, 64: maximum cycles in WAIT before an error completion.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- enable_i  in  1  EX holds an offload op. Held high with stable operands until ready_o & ex_ready_i.
- operator_i  in  ALU_OP_WIDTH  ALU operator.
- operand_a_i, operand_b_i, operand_c_i  in  32 each  operands.
- vector_mode_i  in  2  vector mode.
- flush_i  in  1  kill the current op.
- ex_ready_i  in  1  pipeline accepts the result.
- ready_o  out  1  result valid, or idle with no op.
- result_o  out  32  captured result.
- comparison_result_o  out  1  captured comparison bit.
- error_o  out  1  timeout completion flag, valid with ready_o.
- apu_req_o  out  1  request.
- apu_gnt_i  in  1  grant.
- apu_op_o  out  ALU_OP_WIDTH  registered operator.
- apu_operands_o  out  96  {c,b,a}, registered.
- apu_flags_o  out  2  registered vector mode.
- apu_tag_o  out  TAG_W  request tag.
- apu_rvalid_i  in  1  response valid.
- apu_rtag_i  in  TAG_W  response tag.
- apu_result_i  in  32  response result.
- apu_cmp_i  in  1  response comparison bit.

Behaviour:
- Reset values:
  - state IDLE; apu_req_o 0; tag 0.
  - op/operand/flag registers 0; result_o 0; comparison_result_o 0; error_o 0; timeout counter 0.
  - ready_o = 1 while IDLE and enable_i = 0.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - ready_o = !enable_i.
  - enable_i & !flush_i: capture op, operands and flags into registers, go to REQ. Minimum latency is 1 cycle.
- REQ:
  - apu_req_o = 1. Op, operands, flags and tag stay stable until gnt.
  - On gnt: go to WAIT, clear the timeout counter.
  - gnt & rvalid & rtag == tag in the same cycle: capture the response and go directly to DONE.
- WAIT:
  - apu_req_o = 0; the counter increments each cycle.
  - rvalid & rtag == tag: capture result and cmp, error_o <= 0, go to DONE.
  - rvalid with a non-matching tag: ignore it, a stale response.
  - Counter reaches TIMEOUT-1 with no match: result 0, cmp 0, error_o <= 1, go to DONE.
- DONE:
  - ready_o = 1; result_o, comparison_result_o and error_o are held.
  - On ex_ready_i: go to IDLE. The next op is captured no earlier than the following cycle, so there is no double issue.
- Tag:
  - Increments modulo 2^TAG_W on every grant, registered, so it takes effect for the next request.
  - A late response to a timed-out request is discarded unless the tag has wrapped; this is a documented limitation.
- Flush, which has priority over all other transitions:
  - IDLE: stay in IDLE.
  - REQ without gnt: drop apu_req_o next cycle, go to IDLE.
  - REQ with gnt: go to DRAIN.
  - WAIT: go to DRAIN.
  - DONE: go to IDLE.
- DRAIN:
  - ready_o = 0; the op is not accepted.
  - On a matching rvalid, or on timeout: go to IDLE, discarding the response. error_o is not asserted.
- ready_o is 0 in REQ, WAIT and DRAIN.
- Reset asserted mid-operation returns everything to reset values immediately. An in-flight response after reset is stale and ignored, because the tag restarts at 0.

Decomposition:
- riscv_defines (shared package) holds ALU_OP_WIDTH, the ALU_* operator encodings and the VEC_MODE* encodings.
- A local package enum holds the state type {IDLE, REQ, WAIT, DONE, DRAIN}.
- No sub-module is needed. The timeout counter and tag counter are inline registers.

Test Plan:
- ALU_ADD, a = 5, b = 7; gnt after 2 cycles, rvalid 3 cycles later with tag 0 and result 12 -> ready_o = 1 in DONE, result_o = 12, tag becomes 1, apu_req_o high exactly 3 cycles.
- ALU_SLTS with gnt and rvalid in the same cycle as the first req, apu_cmp_i = 1 -> DONE on the next cycle, comparison_result_o = 1, result_o = apu_result_i.
- In DONE, hold ex_ready_i = 0 for 4 cycles -> result and ready_o stable; then ex_ready_i = 1 -> IDLE. A new op is issued with tag+1 and no duplicate request appears.
- Flush in WAIT; then a stale rvalid with an old tag arrives, then the matching rvalid -> ready_o stays 0 throughout; IDLE after the matching rvalid; result_o unchanged.
- No response for TIMEOUT = 64 cycles -> DONE with error_o = 1 and result_o = 0. The late response with the old tag is ignored by the next op.
- rst_n asserted in REQ -> apu_req_o = 0 and the state is IDLE immediately. After release, ready_o = 1 with enable_i = 0 and tag = 0.
